nx_fifo_rd_stage: RTL
=====================

NX_FIFO_RD_STAGE -- requirements
Module: nx_fifo_rd_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, width of the FIFO read data and output data.
REQ-002 SHALL have parameter DATA_RESET, default 1; 1 = storage entries cleared by reset, 0 = storage not reset.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rdata  input  WIDTH  upstream FIFO head data, valid combinationally when fifo_empty=0.
REQ-008 fifo_ren  output  1  pop strobe to upstream FIFO.
REQ-009 fifo_clear  output  1  clear strobe to upstream FIFO.
REQ-010 flush  input  1  discard all buffered and FIFO-held words.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_data  output  WIDTH  output word.
REQ-013 out_ready  input  1  downstream accepts word when out_valid=1.
REQ-014 buf_cnt  output  2  words held in stage, 0..2.
REQ-015 stat_clr  input  1  clear transfer counter.
REQ-016 xfer_cnt  output  32  saturating count of accepted output words.

Function
REQ-017 SHALL hold up to two words in an ordered head/tail buffer; out_data = head entry, out_valid = (buf_cnt != 0).
REQ-018 SHALL drive out_data to all zeros whenever out_valid=0.
REQ-019 SHALL drive fifo_ren = !fifo_empty && !flush && (buf_cnt < 2); no combinational path from out_ready to fifo_ren.
REQ-020 SHALL never assert fifo_ren while fifo_empty=1.
REQ-021 SHALL capture fifo_rdata on the clock edge ending each cycle with fifo_ren=1.
REQ-022 SHALL give one-cycle latency: word popped in cycle N with buf_cnt=0 appears with out_valid=1 in cycle N+1.
REQ-023 SHALL count a transfer when out_valid && out_ready; the head word is removed on that edge.
REQ-024 buf_cnt=0, pop -> head<=fifo_rdata, cnt 1.
REQ-025 buf_cnt=1, pop, no transfer -> tail<=fifo_rdata, cnt 2.
REQ-026 buf_cnt=1, pop and transfer -> head<=fifo_rdata, cnt 1 (full throughput, one word per cycle).
REQ-027 buf_cnt=1, transfer only -> cnt 0.
REQ-028 buf_cnt=2, transfer -> head<=tail, cnt 1; no pop possible at cnt 2.
REQ-029 SHALL hold head/tail/cnt unchanged when out_valid=1 and out_ready=0 and no pop (stable data under backpressure).
REQ-030 SHALL drive fifo_clear = flush combinationally, with fifo_ren forced to 0 in that cycle.
REQ-031 SHALL set buf_cnt to 0 on the edge ending a flush cycle; a transfer in the flush cycle still counts in xfer_cnt.
REQ-032 SHALL increment xfer_cnt by 1 per transfer, saturating at 32'hFFFF_FFFF with no wrap.
REQ-033 SHALL set xfer_cnt to 0 when stat_clr=1, taking priority over a simultaneous transfer.
REQ-034 SHALL preserve word order: output sequence equals pop sequence minus words discarded by flush.

Reset
REQ-035 With rst_n=0 at a clock edge: buf_cnt=0, out_valid=0, out_data=0, xfer_cnt=0; fifo_ren=0 and fifo_clear=0 during the reset cycle.
REQ-036 DATA_RESET=1 SHALL clear head and tail to 0 on reset; DATA_RESET=0 SHALL leave them unreset.
REQ-037 Reset mid-operation SHALL discard buffered words without asserting fifo_clear; the first word popped after reset release is the first output.

Verification
REQ-038 Reset, FIFO empty -> out_valid=0, out_data=0, fifo_ren=0, xfer_cnt=0 for 10 cycles.
REQ-039 FIFO holds 8 words, out_ready=1 constant -> fifo_ren=1 for 8 consecutive cycles; out_valid=1 for 8 consecutive cycles starting 1 cycle later; data in order; xfer_cnt=8.
REQ-040 FIFO holds 4 words, out_ready=0 -> exactly 2 pops, buf_cnt=2, fifo_ren=0 after that, out_data stable = word0; then out_ready=1 -> words 0..3 in order.
REQ-041 buf_cnt=2, flush=1 for one cycle while out_ready=1 -> fifo_clear=1, fifo_ren=0 that cycle; word0 accepted; next cycle buf_cnt=0, out_valid=0; xfer_cnt +1.
REQ-042 xfer_cnt preloaded to 32'hFFFF_FFFE, 3 transfers -> holds 32'hFFFF_FFFF; then stat_clr=1 with transfer -> 0.
REQ-043 Random fifo_empty/out_ready over 10k cycles -> scoreboard order match, fifo_ren never with fifo_empty=1, buf_cnt never >2.

Source files
------------

// File: rtl/nx_fifo_rd_stage.sv
// nx_fifo_rd_stage: two-entry head/tail buffer draining a show-ahead FIFO into a
// valid/ready consumer at one word per cycle, with flush and a saturating transfer counter.
module nx_fifo_rd_stage #(
    parameter int WIDTH      = 64,
    parameter bit DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             fifo_clear,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       buf_cnt,
    input  logic             stat_clr,
    output logic [31:0]      xfer_cnt
);
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]      xfer_q, xfer_d;
    logic             pop, xfer;

    // Pop depends only on occupancy, never on out_ready, so the FIFO side has no
    // combinational path from the consumer.
    always_comb begin
        pop    = rst_n && !fifo_empty && !flush && (cnt_q != 2'd2);
        xfer   = (cnt_q != 2'd0) && out_ready;
        cnt_d  = flush ? 2'd0 : cnt_q + {1'b0, pop} - {1'b0, xfer};
        head_d = (pop && (cnt_q == 2'd0 || xfer)) ? fifo_rdata :
                 (xfer && cnt_q == 2'd2)          ? tail_q     : head_q;
        tail_d = (pop && cnt_q == 2'd1 && !xfer)  ? fifo_rdata : tail_q;
        xfer_d = stat_clr ? 32'd0 : xfer_q + {31'd0, xfer && !(&xfer_q)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            xfer_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            xfer_q <= xfer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && DATA_RESET) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign fifo_ren   = pop;
    assign fifo_clear = flush && rst_n;
    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = out_valid ? head_q : '0;
    assign buf_cnt    = cnt_q;
    assign xfer_cnt   = xfer_q;
endmodule
